// File: rtl/ahb_arbiter_pkg.sv
// Shared AHB encodings, arbiter FSM state type and burst-length decode.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_BURST  = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_e;

  // Beats remaining after the NONSEQ beat; 0 means "not a fixed-length burst".
  function automatic logic [3:0] burst_beats_m1(input logic [2:0] hburst);
    logic [3:0] n;
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  n = 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  n = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: n = 4'd15;
      default:                      n = 4'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// Arbiter bus bundle: requests and muxed owner controls in, grant/ownership out.
// Handshake: hready=1 on a rising edge completes a transfer; nothing advances on hready=0 edges.
interface ahb_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int MW          = 2
);
  logic [NUM_MASTERS-1:0] hbusreq;
  logic [NUM_MASTERS-1:0] hlock;
  logic [1:0]             htrans;
  logic [2:0]             hburst;
  logic                   hready;
  logic                   hresp;
  logic [NUM_MASTERS-1:0] hgrant;
  logic [MW-1:0]          hmaster;
  logic [MW-1:0]          hmaster_d;
  logic                   hmastlock;

  modport master (
    output hbusreq, hlock, htrans, hburst, hready, hresp,
    input  hgrant, hmaster, hmaster_d, hmastlock
  );

  modport slave (
    input  hbusreq, hlock, htrans, hburst, hready, hresp,
    output hgrant, hmaster, hmaster_d, hmastlock
  );
endinterface

// File: rtl/ahb_arbiter_pick.sv
// Combinational N-way picker: round-robin from rr_ptr+1, or lowest index wins
// when AHB_ARB_FIXED_PRIO_EN is defined. Parks on DEFAULT_MASTER with no requests.
module ahb_arb_pick #(
  parameter int NUM_MASTERS    = 4,
  parameter int MW             = 2,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [MW-1:0]          rr_ptr,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [MW-1:0]          idx
);

  logic [MW-1:0] j;

`ifdef AHB_ARB_FIXED_PRIO_EN
  logic unused_rr_ptr;
  assign unused_rr_ptr = ^rr_ptr;
`endif

  // Scanning from the far end and overwriting leaves the nearest requester in idx.
  always_comb begin
    idx = MW'(DEFAULT_MASTER);
    j   = '0;
`ifdef AHB_ARB_FIXED_PRIO_EN
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      j = MW'(i);
      if (hbusreq[j]) idx = j;
    end
`else
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      j = MW'((int'(rr_ptr) + i) % NUM_MASTERS);
      if (hbusreq[j]) idx = j;
    end
`endif
    grant      = '0;
    grant[idx] = 1'b1;
  end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: address-phase grant FSM (ARB/BURST/LOCKED) and data-phase owner.
// Define AHB_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin picks.
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int MW             = 2,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic         hclk,
  input  logic         hresetn,
  ahb_arbiter_if.slave bus,
  output arb_state_e   state
);

  localparam logic [NUM_MASTERS-1:0] RST_GRANT =
    {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;
  localparam logic [MW-1:0] RST_IDX = MW'(DEFAULT_MASTER);

  logic [NUM_MASTERS-1:0] pick_grant;
  logic [MW-1:0]          pick_idx;
  logic [NUM_MASTERS-1:0] hgrant_q;
  logic [MW-1:0]          hmaster_q;
  logic [MW-1:0]          hmaster_d_q;
  logic                   hmastlock_q;
  logic [3:0]             cnt;
  logic                   err_flag;
  logic                   owner_lock;
  logic                   is_idle;
  logic                   is_nonseq;
  logic                   is_seq;
  logic [3:0]             beats;

  // The current owner doubles as the round-robin pointer.
  ahb_arb_pick #(
    .NUM_MASTERS   (NUM_MASTERS),
    .MW            (MW),
    .DEFAULT_MASTER(DEFAULT_MASTER)
  ) u_pick (
    .hbusreq(bus.hbusreq),
    .rr_ptr (hmaster_q),
    .grant  (pick_grant),
    .idx    (pick_idx)
  );

  assign owner_lock = bus.hlock[hmaster_q];
  assign is_idle    = (bus.htrans == HTRANS_IDLE);
  assign is_nonseq  = (bus.htrans == HTRANS_NONSEQ);
  assign is_seq     = (bus.htrans == HTRANS_SEQ);
  assign beats      = burst_beats_m1(bus.hburst);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state       <= ST_ARB;
      cnt         <= '0;
      err_flag    <= 1'b0;
      hgrant_q    <= RST_GRANT;
      hmaster_q   <= RST_IDX;
      hmaster_d_q <= RST_IDX;
      hmastlock_q <= 1'b0;
    end else if (!bus.hready) begin
      // First ERROR cycle: remember it so the next completed transfer re-arbitrates.
      if (bus.hresp) begin
        err_flag <= 1'b1;
        cnt      <= '0;
      end
    end else begin
      hmaster_d_q <= hmaster_q;
      err_flag    <= 1'b0;
      case (state)
        ST_ARB: begin
          if (!err_flag && is_nonseq && owner_lock) begin
            state       <= ST_LOCKED;
            hmastlock_q <= 1'b1;
          end else if (!err_flag && is_nonseq && beats != 4'd0) begin
            state <= ST_BURST;
            cnt   <= beats;
          end else begin
            hgrant_q  <= pick_grant;
            hmaster_q <= pick_idx;
          end
        end
        ST_BURST: begin
          // Last beat, error or early termination hands over on this same edge.
          if (err_flag || is_idle || is_nonseq || (is_seq && cnt == 4'd1)) begin
            state     <= ST_ARB;
            cnt       <= '0;
            hgrant_q  <= pick_grant;
            hmaster_q <= pick_idx;
          end else if (is_seq) begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_LOCKED: begin
          if (!owner_lock) begin
            state       <= ST_ARB;
            hmastlock_q <= 1'b0;
            cnt         <= '0;
            hgrant_q    <= pick_grant;
            hmaster_q   <= pick_idx;
          end
        end
        default: state <= ST_ARB;
      endcase
    end
  end

  assign bus.hgrant    = hgrant_q;
  assign bus.hmaster   = hmaster_q;
  assign bus.hmaster_d = hmaster_d_q;
  assign bus.hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Table-driven bench for ahb_arbiter with an expected-value scoreboard queue.
module tb_ahb_arbiter;
  import ahb_pkg::*;

  localparam int N  = 4;
  localparam int MW = 2;
  localparam int W  = 11;

  typedef struct {
    logic [3:0] req;
    logic [3:0] lock;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       rdy;
    logic       resp;
    logic       pulse_rst;
    logic [1:0] e_hm;
    logic [1:0] e_hmd;
    logic       e_lk;
    logic [1:0] e_st;
  } vec_t;

  logic       hclk = 1'b0;
  logic       hresetn;
  arb_state_e state;

  vec_t         vecs[$];
  string        vnames[$];
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  ahb_arbiter_if #(.NUM_MASTERS(N), .MW(MW)) bus ();

  ahb_arbiter #(.NUM_MASTERS(N), .MW(MW), .DEFAULT_MASTER(0)) dut (
    .hclk   (hclk),
    .hresetn(hresetn),
    .bus    (bus),
    .state  (state)
  );

  // clock / reset
  always #5 hclk = ~hclk;

  function automatic logic [W-1:0] pack(input logic [1:0] hm, input logic [1:0] hmd,
                                        input logic lk, input logic [1:0] st);
    logic [3:0] g;
    g = 4'b0001 << hm;
    return {g, hm, hmd, lk, st};
  endfunction

  task automatic add(input string nm, input logic [3:0] req, input logic [3:0] lock,
                     input logic [1:0] tr, input logic [2:0] bu, input logic rdy,
                     input logic resp, input logic prst, input logic [1:0] hm,
                     input logic [1:0] hmd, input logic lk, input arb_state_e st);
    vec_t v;
    v.req = req; v.lock = lock; v.trans = tr; v.burst = bu; v.rdy = rdy; v.resp = resp;
    v.pulse_rst = prst; v.e_hm = hm; v.e_hmd = hmd; v.e_lk = lk; v.e_st = 2'(st);
    vecs.push_back(v);
    vnames.push_back(nm);
  endtask

  task automatic check_out();
    logic [W-1:0] act;
    logic [W-1:0] exp;
    string        nm;
    act = {bus.hgrant, bus.hmaster, bus.hmaster_d, bus.hmastlock, 2'(state)};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %b required a queued expectation", act);
    end else begin
      exp = exp_q.pop_front();
      nm  = name_q.pop_front();
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s: got gnt/hm/hmd/lk/st=%b required %b", nm, act, exp);
      end
    end
  endtask

  // driver: called at a negedge, returns at the next negedge
  task automatic apply(input vec_t v, input string nm);
    bus.hbusreq = v.req;
    bus.hlock   = v.lock;
    bus.htrans  = v.trans;
    bus.hburst  = v.burst;
    bus.hready  = v.rdy;
    bus.hresp   = v.resp;
    exp_q.push_back(pack(v.e_hm, v.e_hmd, v.e_lk, v.e_st));
    name_q.push_back(nm);
    @(posedge hclk);
    #1;
    check_out();
    @(negedge hclk);
  endtask

  task automatic async_reset_pulse();
    #2 hresetn = 1'b0;
    #1;
    exp_q.push_back(pack(2'd0, 2'd0, 1'b0, 2'(ST_ARB)));
    name_q.push_back("async_reset_mid_burst");
    check_out();
    @(negedge hclk);
    hresetn = 1'b1;
  endtask

  initial begin
    // parked, no requests
    add("park_a", 4'h0, 4'h0, HTRANS_IDLE, HBURST_SINGLE, 1, 0, 0, 0, 0, 0, ST_ARB);
    add("park_b", 4'h0, 4'h0, HTRANS_IDLE, HBURST_SINGLE, 1, 0, 0, 0, 0, 0, ST_ARB);
    // all requesting, single transfers
`ifdef AHB_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 5; i++)
      add("single_prio", 4'hF, 4'h0, HTRANS_NONSEQ, HBURST_SINGLE, 1, 0, 0, 0, 0, 0, ST_ARB);
`else
    add("rr_1", 4'hF, 4'h0, HTRANS_NONSEQ, HBURST_SINGLE, 1, 0, 0, 1, 0, 0, ST_ARB);
    add("rr_2", 4'hF, 4'h0, HTRANS_NONSEQ, HBURST_SINGLE, 1, 0, 0, 2, 1, 0, ST_ARB);
    add("rr_3", 4'hF, 4'h0, HTRANS_NONSEQ, HBURST_SINGLE, 1, 0, 0, 3, 2, 0, ST_ARB);
    add("rr_0", 4'hF, 4'h0, HTRANS_NONSEQ, HBURST_SINGLE, 1, 0, 0, 0, 3, 0, ST_ARB);
    add("rr_1b", 4'hF, 4'h0, HTRANS_NONSEQ, HBURST_SINGLE, 1, 0, 0, 1, 0, 0, ST_ARB);
    // get M1 onto the bus in fixed mode too; round-robin from 1 with only M1 asking
`endif
`ifdef AHB_ARB_FIXED_PRIO_EN
    add("to_m1", 4'h2, 4'h0, HTRANS_IDLE, HBURST_SINGLE, 1, 0, 0, 1, 0, 0, ST_ARB);
`endif
    // M1 INCR4 with M2 waiting
    add("incr4_nseq", 4'h6, 4'h0, HTRANS_NONSEQ, HBURST_INCR4, 1, 0, 0, 1, 1, 0, ST_BURST);
    add("incr4_b2",   4'h6, 4'h0, HTRANS_SEQ,    HBURST_INCR4, 1, 0, 0, 1, 1, 0, ST_BURST);
    add("incr4_b3",   4'h6, 4'h0, HTRANS_SEQ,    HBURST_INCR4, 1, 0, 0, 1, 1, 0, ST_BURST);
    add("incr4_last", 4'h4, 4'h0, HTRANS_SEQ,    HBURST_INCR4, 1, 0, 0, 2, 1, 0, ST_ARB);
    // same with one BUSY
    add("back_to_m1", 4'h2, 4'h0, HTRANS_IDLE,   HBURST_SINGLE, 1, 0, 0, 1, 2, 0, ST_ARB);
    add("busy_nseq",  4'h6, 4'h0, HTRANS_NONSEQ, HBURST_INCR4,  1, 0, 0, 1, 1, 0, ST_BURST);
    add("busy_b2",    4'h6, 4'h0, HTRANS_SEQ,    HBURST_INCR4,  1, 0, 0, 1, 1, 0, ST_BURST);
    add("busy_hold",  4'h6, 4'h0, HTRANS_BUSY,   HBURST_INCR4,  1, 0, 0, 1, 1, 0, ST_BURST);
    add("busy_b3",    4'h6, 4'h0, HTRANS_SEQ,    HBURST_INCR4,  1, 0, 0, 1, 1, 0, ST_BURST);
    add("busy_last",  4'h4, 4'h0, HTRANS_SEQ,    HBURST_INCR4,  1, 0, 0, 2, 1, 0, ST_ARB);
    // M3 locked INCR8 with an ERROR beat inside; lock only drops via hlock
    add("to_m3",     4'h8, 4'h0, HTRANS_IDLE,   HBURST_SINGLE, 1, 0, 0, 3, 2, 0, ST_ARB);
    add("lock_nseq", 4'hF, 4'h8, HTRANS_NONSEQ, HBURST_INCR8,  1, 0, 0, 3, 3, 1, ST_LOCKED);
    for (int i = 0; i < 3; i++)
      add("lock_seq", 4'hF, 4'h8, HTRANS_SEQ, HBURST_INCR8, 1, 0, 0, 3, 3, 1, ST_LOCKED);
    add("lock_err",  4'hF, 4'h8, HTRANS_SEQ, HBURST_INCR8, 0, 1, 0, 3, 3, 1, ST_LOCKED);
    for (int i = 0; i < 4; i++)
      add("lock_seq2", 4'hF, 4'h8, HTRANS_SEQ, HBURST_INCR8, 1, 0, 0, 3, 3, 1, ST_LOCKED);
    for (int i = 0; i < 2; i++)
      add("lock_trail", 4'hF, 4'h8, HTRANS_NONSEQ, HBURST_SINGLE, 1, 0, 0, 3, 3, 1, ST_LOCKED);
    add("lock_release", 4'hF, 4'h0, HTRANS_IDLE, HBURST_SINGLE, 1, 0, 0, 0, 3, 0, ST_ARB);
    // M0 INCR16, ERROR on beat 5, M2 waiting
    add("i16_nseq", 4'h5, 4'h0, HTRANS_NONSEQ, HBURST_INCR16, 1, 0, 0, 0, 0, 0, ST_BURST);
    for (int i = 0; i < 3; i++)
      add("i16_seq", 4'h5, 4'h0, HTRANS_SEQ, HBURST_INCR16, 1, 0, 0, 0, 0, 0, ST_BURST);
    add("i16_err1", 4'h5, 4'h0, HTRANS_SEQ, HBURST_INCR16, 0, 1, 0, 0, 0, 0, ST_BURST);
    add("i16_err2", 4'h4, 4'h0, HTRANS_SEQ, HBURST_INCR16, 1, 1, 0, 2, 0, 0, ST_ARB);
    // M2 burst interrupted by asynchronous reset; burst must be abandoned
    add("m2_nseq",   4'h4, 4'h0, HTRANS_NONSEQ, HBURST_INCR4, 1, 0, 0, 2, 2, 0, ST_BURST);
    add("m2_seq",    4'h4, 4'h0, HTRANS_SEQ,    HBURST_INCR4, 1, 0, 0, 2, 2, 0, ST_BURST);
    add("post_reset", 4'h4, 4'h0, HTRANS_SEQ,   HBURST_INCR4, 1, 0, 1, 2, 0, 0, ST_ARB);
    // M1 and M3 requesting
`ifdef AHB_ARB_FIXED_PRIO_EN
    add("fp_a", 4'hA, 4'h0, HTRANS_NONSEQ, HBURST_SINGLE, 1, 0, 0, 1, 2, 0, ST_ARB);
    add("fp_b", 4'hA, 4'h0, HTRANS_NONSEQ, HBURST_SINGLE, 1, 0, 0, 1, 1, 0, ST_ARB);
    add("fp_c", 4'hA, 4'h0, HTRANS_NONSEQ, HBURST_SINGLE, 1, 0, 0, 1, 1, 0, ST_ARB);
    add("fp_d", 4'hA, 4'h0, HTRANS_NONSEQ, HBURST_SINGLE, 1, 0, 0, 1, 1, 0, ST_ARB);
`else
    add("rr13_a", 4'hA, 4'h0, HTRANS_NONSEQ, HBURST_SINGLE, 1, 0, 0, 3, 2, 0, ST_ARB);
    add("rr13_b", 4'hA, 4'h0, HTRANS_NONSEQ, HBURST_SINGLE, 1, 0, 0, 1, 3, 0, ST_ARB);
    add("rr13_c", 4'hA, 4'h0, HTRANS_NONSEQ, HBURST_SINGLE, 1, 0, 0, 3, 1, 0, ST_ARB);
    add("rr13_d", 4'hA, 4'h0, HTRANS_NONSEQ, HBURST_SINGLE, 1, 0, 0, 1, 3, 0, ST_ARB);
`endif
    add("m1_drops", 4'h8, 4'h0, HTRANS_NONSEQ, HBURST_SINGLE, 1, 0, 0, 3, 1, 0, ST_ARB);
    add("wait_hold", 4'h0, 4'h0, HTRANS_IDLE, HBURST_SINGLE, 0, 0, 0, 3, 1, 0, ST_ARB);
    add("park_back", 4'h0, 4'h0, HTRANS_IDLE, HBURST_SINGLE, 1, 0, 0, 0, 3, 0, ST_ARB);

    // reset state
    hresetn     = 1'b0;
    bus.hbusreq = '0;
    bus.hlock   = '0;
    bus.htrans  = HTRANS_IDLE;
    bus.hburst  = HBURST_SINGLE;
    bus.hready  = 1'b1;
    bus.hresp   = 1'b0;
    repeat (2) @(negedge hclk);
    exp_q.push_back(pack(2'd0, 2'd0, 1'b0, 2'(ST_ARB)));
    name_q.push_back("reset_values");
    check_out();
    hresetn = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      if (vecs[k].pulse_rst) async_reset_pulse();
      apply(vecs[k], vnames[k]);
    end

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d pending required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
